// File: rtl/pr_timer_pkg.sv
// Shared definitions for pr_timer: register offsets, CTRL bit positions, MODE
// encodings, FSM states and the bridge address windows of the two timers.
package pr_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [31:0] TIMER0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7f10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Only 2'b01 reloads; both 2'b1x encodings fall back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/pr_timer_prescaler.sv
// Free-running prescale counter for pr_timer; tick pulses once every 2^ps cycles.
// Instantiated only when TIMER_PRESCALE_EN is defined.
module pr_timer_prescaler #(
  parameter int PS_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [PS_WIDTH-1:0] ps,
  output logic                tick
);

  localparam int DIV_W = 2 ** PS_WIDTH;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_mask;

  // tick whenever the low ps bits of the counter are all ones
  always_comb begin
    div_mask = ({{(DIV_W-1){1'b0}}, 1'b1} << ps) - {{(DIV_W-1){1'b0}}, 1'b1};
    tick     = ((div_cnt & div_mask) == div_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pr_timer.sv
// Programmable down-counter with CTRL/PRESET/COUNT registers and a maskable irq.
// Optional prescaler is enabled by defining TIMER_PRESCALE_EN.
module pr_timer
  import pr_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int PS_WIDTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_nx;
  logic                 en, en_nx;
  logic [1:0]           mode, mode_nx;
  logic                 im, im_nx;
  logic [CNT_WIDTH-1:0] preset, preset_nx;
  logic [CNT_WIDTH-1:0] count, count_nx;
  logic                 irq_flag, flag_nx;
  logic                 ctrl_wr, preset_wr;
  logic                 tick;

  assign ctrl_wr   = we && (addr == REG_CTRL);
  assign preset_wr = we && (addr == REG_PRESET);

`ifdef TIMER_PRESCALE_EN
  logic [PS_WIDTH-1:0] ps, ps_nx;
  logic                ps_clear;

  assign ps_clear = ctrl_wr | preset_wr | (state == ST_LOAD);
  assign ps_nx    = ctrl_wr ? din[CTRL_PS_LO +: PS_WIDTH] : ps;

  pr_timer_prescaler #(.PS_WIDTH(PS_WIDTH)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (ps_clear),
    .ps    (ps),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // A CTRL/PRESET write overrides whatever the FSM would have done this cycle.
  always_comb begin
    state_nx  = state;
    en_nx     = en;
    mode_nx   = mode;
    im_nx     = im;
    preset_nx = preset;
    count_nx  = count;
    flag_nx   = irq_flag;
    if (ctrl_wr || preset_wr) begin
      if (ctrl_wr) begin
        en_nx   = din[CTRL_EN];
        mode_nx = din[CTRL_MODE_LO +: 2];
        im_nx   = din[CTRL_IM];
      end else begin
        preset_nx = din[CNT_WIDTH-1:0];
      end
      state_nx = ST_IDLE;
      flag_nx  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) state_nx = ST_LOAD;
          else    state_nx = ST_IDLE;
        end
        ST_LOAD: begin
          count_nx = preset;
          if (is_reload(mode)) flag_nx = 1'b0;
          else                 flag_nx = irq_flag;
          state_nx = ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state_nx = ST_IDLE;
          end else if (tick) begin
            if (count <= CNT_ONE) begin
              count_nx = '0;
              state_nx = ST_INT;
            end else begin
              count_nx = count - CNT_ONE;
            end
          end else begin
            count_nx = count;
          end
        end
        ST_INT: begin
          flag_nx = 1'b1;
          if (is_reload(mode)) begin
            state_nx = ST_LOAD;
          end else begin
            en_nx    = 1'b0;
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      ps       <= '0;
`endif
    end else begin
      state    <= state_nx;
      en       <= en_nx;
      mode     <= mode_nx;
      im       <= im_nx;
      preset   <= preset_nx;
      count    <= count_nx;
      irq_flag <= flag_nx;
`ifdef TIMER_PRESCALE_EN
      ps       <= ps_nx;
`endif
    end
  end

  always_comb begin
    dout = 32'h0000_0000;
    case (addr)
      REG_CTRL: begin
        dout[CTRL_EN]            = en;
        dout[CTRL_MODE_LO +: 2]  = mode;
        dout[CTRL_IM]            = im;
`ifdef TIMER_PRESCALE_EN
        dout[CTRL_PS_LO +: PS_WIDTH] = ps;
`endif
      end
      REG_PRESET: dout[CNT_WIDTH-1:0] = preset;
      REG_COUNT:  dout[CNT_WIDTH-1:0] = count;
      REG_RSVD:   dout = 32'h0000_0000;
      default:    dout = 32'h0000_0000;
    endcase
  end

  assign irq = irq_flag & im;

endmodule

// File: tb/tb_pr_timer.sv
// Self-checking bench for pr_timer: directed scenarios plus random bus traffic,
// compared against a closed-form model driven by cycles elapsed since the last arm.
module tb_pr_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pr_timer dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  // Model: register contents plus "armed" and edges elapsed since the arming write.
  bit              m_en;
  bit [1:0]        m_mode;
  bit              m_im;
  bit [3:0]        m_ps;
  longint unsigned m_preset;
  longint unsigned m_hc;
  bit              m_armed;
  longint unsigned m_e;

  function automatic longint unsigned m_len();
    return (m_preset == 0) ? 64'd1 : m_preset;
  endfunction

  function automatic longint unsigned m_div();
    return 64'd1 << m_ps;
  endfunction

  function automatic bit m_reload();
    return (m_mode == 2'b01);
  endfunction

  function automatic bit m_expired();
    return m_armed && !m_reload() && (m_e >= 3 + m_len() * m_div());
  endfunction

  function automatic longint unsigned m_count();
    longint unsigned k;
    if (!m_armed || m_e < 2) return m_hc;
    if (m_reload()) k = (m_e - 2) % (m_len() + 2);
    else            k = (m_e - 2) / m_div();
    return (m_preset > k) ? m_preset - k : 64'd0;
  endfunction

  function automatic bit m_flag();
    if (!m_armed) return 1'b0;
    if (m_reload()) return (m_e >= 3) && (((m_e - 2) % (m_len() + 2)) == m_len() + 1);
    return m_expired();
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_ps, m_im, m_mode, m_en && !m_expired()};
      2'd1:    return m_preset[31:0];
      2'd2:    return m_count();
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 1'b0; m_mode = 2'b00; m_im = 1'b0; m_ps = 4'h0;
    m_preset = 0; m_hc = 0; m_armed = 1'b0; m_e = 0;
  endtask

  task automatic m_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
    if (w && a < 2'd2) begin
      m_hc = m_count();
      m_en = m_en && !m_expired();
      if (a == 2'd0) begin
        m_en   = d[0];
        m_mode = d[2:1];
        m_im   = d[3];
`ifdef TIMER_PRESCALE_EN
        m_ps   = d[7:4];
`endif
      end else begin
        m_preset = d;
      end
      m_armed = m_en;
      m_e     = 0;
    end else if (m_armed) begin
      m_e = m_e + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, then sample readback addr ra.
  task automatic cycle(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [1:0] ra);
    @(negedge clk);
    we = w; addr = a; din = d;
    @(posedge clk);
    m_edge(w, a, d);
    #2;
    we = 1'b0; addr = ra;
    #1;
    check("irq_model", {31'h0, irq}, {31'h0, m_flag() & m_im});
    check("dout_model", dout, m_read(ra));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [1:0] ra);
    cycle(1'b1, a, d, ra);
  endtask

  task automatic idle(input logic [1:0] ra);
    cycle(1'b0, 2'd0, 32'h0, ra);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'h0;
    m_reset();
    #1;
    check("rst_ctrl", dout, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    addr = 2'd2; #1;
    check("rst_count", dout, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of a count
    wr(2'd1, 32'h40, 2'd2);
    wr(2'd0, 32'h1, 2'd2);
    for (int i = 0; i < 34; i++) idle(2'd2);
    check("mid_count", dout, 32'h20);
    #1 reset = 1'b0;
    #1 check("async_count", dout, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    addr = 2'd0; #1;
    check("async_ctrl", dout, 32'h0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) idle(2'd2);
    check("no_resume", dout, 32'h0);

    // One-shot with irq enabled: latency N+3, EN self-clears, irq held
    wr(2'd1, 32'd5, 2'd0);
    wr(2'd0, 32'h9, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      idle(2'd0);
      if (i == 7) check("oneshot_pre", {31'h0, irq}, 32'h0);
      if (i == 8) begin
        check("oneshot_irq", {31'h0, irq}, 32'h1);
        check("oneshot_ctrl", dout, 32'h8);
      end
    end
    for (int i = 0; i < 3; i++) idle(2'd2);
    check("oneshot_hold", {31'h0, irq}, 32'h1);
    wr(2'd0, 32'h8, 2'd0);
    check("oneshot_clr", {31'h0, irq}, 32'h0);

    // Auto-reload: one-cycle pulses every N+2 cycles
    wr(2'd1, 32'd3, 2'd2);
    wr(2'd0, 32'hB, 2'd2);
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      idle(2'd2);
      if (irq) pulses++;
    end
    check("reload_pulses", pulses, 32'd2);
    wr(2'd0, 32'h0, 2'd0);

    // Masked one-shot: EN clears, irq never visible, flag dropped by the write
    wr(2'd1, 32'd2, 2'd0);
    wr(2'd0, 32'h1, 2'd0);
    for (int i = 0; i < 8; i++) idle(2'd0);
    check("masked_ctrl", dout, 32'h0);
    wr(2'd0, 32'h8, 2'd0);
    check("masked_irq", {31'h0, irq}, 32'h0);

    // CTRL write lands on the INT cycle: write wins, no irq
    wr(2'd1, 32'd2, 2'd0);
    wr(2'd0, 32'h9, 2'd0);
    for (int i = 0; i < 4; i++) idle(2'd0);
    wr(2'd0, 32'hB, 2'd0);
    check("int_race_ctrl", dout, 32'hB);
    check("int_race_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) idle(2'd2);
    wr(2'd0, 32'h0, 2'd2);

    // Writes to COUNT and the reserved offset change nothing
    wr(2'd2, 32'h1234, 2'd2);
    wr(2'd3, 32'h1234, 2'd3);
    check("rsvd_read", dout, 32'h0);
    idle(2'd1);
    check("preset_kept", dout, 32'd2);

`ifdef TIMER_PRESCALE_EN
    wr(2'd1, 32'd2, 2'd0);
    wr(2'd0, 32'h29, 2'd0);
    for (int i = 1; i <= 11; i++) begin
      idle(2'd0);
      if (i == 10) check("ps_pre", {31'h0, irq}, 32'h0);
      if (i == 11) begin
        check("ps_irq", {31'h0, irq}, 32'h1);
        check("ps_ctrl", dout, 32'h28);
      end
    end
`endif

    // Random bus traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        if (a == 2'd0)      d = {$urandom_range(0, 32'hFFFF) , 16'h0} | 32'($urandom_range(0, 15));
        else if (a == 2'd1) d = ($urandom_range(0, 19) == 0) ? 32'd40 : 32'($urandom_range(0, 6));
        else                d = $urandom;
        wr(a, d, 2'($urandom_range(0, 3)));
      end else begin
        idle(2'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
